// File: rtl/asyn_inter_b_mc.sv
// Multi-channel clk_B receiver: synchronises per-channel starts from clk A and runs a programmable busy countdown.
// Latency: accept NUM_SYNC_B edges after the start level is first sampled; done_B pulses max(lat_cfg,1) edges after that.
module asyn_inter_b_mc #(
  parameter int NUM_CH     = 4,
  parameter int NUM_SYNC_B = 2,
  parameter int LAT_W      = 8,
  parameter int EDGE_MODE  = 0
) (
  input  logic              clk_B,
  input  logic              rst_n_B,
  input  logic [NUM_CH-1:0] start_AtB,
  input  logic [LAT_W-1:0]  lat_cfg,
  input  logic              soft_clr,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] done_B,
  output logic [NUM_CH-1:0] done_BtA,
  output logic [NUM_CH-1:0] busy_B,
  output logic [NUM_CH-1:0] err_ovl,
  output logic [NUM_CH-1:0] err_sticky
);

  typedef enum logic {IDLE, BUSY} state_t;

  // A zero latency request runs as a single-cycle countdown.
  logic [LAT_W-1:0] lat_eff;
  assign lat_eff = (lat_cfg == '0) ? LAT_W'(1) : lat_cfg;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [NUM_SYNC_B-1:0] sync_q;
    logic                  hist_q;
    logic                  start_b;
    state_t                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  dba_q, dba_d;
    logic                  ovl_q, ovl_d;
    logic                  sticky_q, sticky_d;

    // Sync chain and history survive soft_clr so a held level cannot re-trigger.
    always_ff @(posedge clk_B or negedge rst_n_B) begin
      if (!rst_n_B) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[NUM_SYNC_B-2:0], start_AtB[i]};
        hist_q <= sync_q[NUM_SYNC_B-1];
      end
    end

    if (EDGE_MODE == 0) begin : g_level
      assign start_b = sync_q[NUM_SYNC_B-1] & ~hist_q;
    end else begin : g_toggle
      assign start_b = sync_q[NUM_SYNC_B-1] ^ hist_q;
    end

    always_ff @(posedge clk_B or negedge rst_n_B) begin
      if (!rst_n_B) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        done_q   <= 1'b0;
        dba_q    <= 1'b0;
        ovl_q    <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        done_q   <= done_d;
        dba_q    <= dba_d;
        ovl_q    <= ovl_d;
        sticky_q <= sticky_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      dba_d    = dba_q;
      ovl_d    = 1'b0;
      sticky_d = err_clr ? 1'b0 : sticky_q;
      case (state_q)
        IDLE: begin
          if (start_b) begin
            state_d = BUSY;
            cnt_d   = lat_eff;
            if (EDGE_MODE == 0) dba_d = 1'b0;
          end
        end
        BUSY: begin
          // A start while counting is flagged and dropped; the count is untouched.
          if (start_b) begin
            ovl_d    = 1'b1;
            sticky_d = 1'b1;
          end
          if (cnt_q > LAT_W'(1)) begin
            cnt_d = cnt_q - LAT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            dba_d   = (EDGE_MODE != 0) ? ~dba_q : 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (soft_clr) begin
        state_d  = IDLE;
        cnt_d    = '0;
        done_d   = 1'b0;
        dba_d    = 1'b0;
        ovl_d    = 1'b0;
        sticky_d = 1'b0;
      end
    end

    assign done_B[i]     = done_q;
    assign done_BtA[i]   = dba_q;
    assign busy_B[i]     = (state_q == BUSY);
    assign err_ovl[i]    = ovl_q;
    assign err_sticky[i] = sticky_q;
  end

endmodule

// File: doc/asyn_inter_b_mc.md
Name: asyn_inter_B_mc

Overview:
Multi-channel, parametrised successor to the clk_B-side handshake receiver. It takes NUM_CH start signals from the clk A domain and synchronises each into clk_B. For each channel it runs a programmable-latency busy countdown and returns a done pulse locally plus a done indication back to clk A. It adds a toggle (any-edge) protocol mode, detection of starts that arrive while a channel is busy, and a synchronous soft clear.

Parameters:
NUM_CH, 4, number of independent channels (>=1).
NUM_SYNC_B, 2, synchroniser flops per channel (>=2).
LAT_W, 8, width of the latency configuration.
EDGE_MODE, 0, start protocol. 0 = level protocol, rising edge starts. 1 = toggle protocol, either edge starts.

Ports:
clk_B  input  1  clk_B domain clock.
rst_n_B  input  1  asynchronous active-low reset.
start_AtB  input  NUM_CH  per-channel start from clk A; asynchronous to clk_B.
lat_cfg  input  LAT_W  compute latency in clk_B cycles; shared by all channels; quasi-static.
soft_clr  input  1  synchronous clear of all channel state, sync chains excluded.
err_clr  input  1  clears err_sticky.
done_B  output  NUM_CH  one-cycle completion pulse per channel.
done_BtA  output  NUM_CH  completion indication to clk A.
busy_B  output  NUM_CH  channel is counting.
err_ovl  output  NUM_CH  one-cycle pulse: start detected while busy.
err_sticky  output  NUM_CH  latched err_ovl.

Behaviour:
- Reset (rst_n_B=0, asynchronous): all sync flops, the edge-history flop, counters, and all outputs go to 0.
- Synchronisation: a per-channel chain of NUM_SYNC_B flops, followed by one history flop.
- Start detection (start_B[i], internal, combinational from registers):
  - EDGE_MODE=0: sync_last & ~hist.
  - EDGE_MODE=1: sync_last ^ hist.
- Start timing: call edge 0 the first clk_B edge that samples a new start_AtB level. start_B[i] is high during the cycle after edge NUM_SYNC_B-1, and the start is accepted or rejected at edge NUM_SYNC_B.
- Channel FSM, per channel, states IDLE and BUSY:
  - IDLE & start_B: on the edge, cnt <= max(lat_cfg,1); busy_B <= 1; go to BUSY. In EDGE_MODE=0, done_BtA[i] <= 0 on the same edge.
  - BUSY with cnt>1: cnt <= cnt-1.
  - BUSY with cnt==1: go to IDLE; busy_B <= 0; done_B[i] <= 1 for exactly one cycle.
    - EDGE_MODE=0: done_BtA[i] <= 1, held until the next accepted start.
    - EDGE_MODE=1: done_BtA[i] toggles.
  - Latency: done_B[i] is high during the cycle following edge NUM_SYNC_B + max(lat_cfg,1). lat_cfg=0 behaves as 1.
  - lat_cfg is captured at acceptance only. Changing it while BUSY has no effect on the running channel.
- Overlap:
  - A start_B[i] while BUSY is rejected; this includes the cnt==1 completion cycle.
  - The rejected start causes err_ovl[i] to pulse for 1 cycle and err_sticky[i] <= 1.
  - The count continues unaffected and done still fires on schedule.
  - A rejected start is not queued.
- err_sticky:
  - Cleared by err_clr on the next edge.
  - A simultaneous new overlap wins, so err_sticky stays 1.
- soft_clr: on the edge, cnt, busy_B, done_B, done_BtA, err_ovl and err_sticky all go to 0.
  - The sync chain and history flop are retained, so no spurious start is produced after the clear.
  - A start_B coinciding with soft_clr is dropped.
- Channels are fully independent. Simultaneous starts and dones on different channels do not interact.
- Single-cycle glitches on start_AtB shorter than one clk_B period are not guaranteed to be detected. Clk A must hold each level for >= NUM_SYNC_B+1 clk_B cycles.

Test Plan:
1. Default params, lat_cfg=5. Raise start_AtB[0] -> start accepted at edge 2; done_B[0] high only in the cycle after edge 7; done_BtA[0]=1 from edge 7; busy_B[0] high from edge 2 to edge 7.
2. Continuing from 1, drop then re-raise start_AtB[0]. At re-accept, done_BtA[0] returns to 0, then goes back to 1 after a further 5 cycles. The falling edge of start_AtB[0] produces no start.
3. lat_cfg=8; raise a second start on channel 1 four cycles after the first was accepted -> err_ovl[1] single pulse, err_sticky[1]=1, exactly one done_B[1] at acceptance+8. Pulse err_clr -> err_sticky[1]=0.
4. EDGE_MODE=1, lat_cfg=3, toggle start_AtB[2] 0->1, wait, then 1->0 -> two done_B[2] pulses, each 3 cycles after its acceptance; done_BtA[2] goes 0->1->0.
5. All 4 channels started on the same cycle with lat_cfg=0 -> all done_B pulse together one cycle after acceptance; no err.
6. Assert soft_clr while channel 3 is at cnt=2, and separately assert rst_n_B low mid-count -> outputs go to 0 immediately (rst_n_B) or on the next edge (soft_clr); no done_B afterwards; the next start is accepted normally.
